// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder: the only arithmetic cell of the serial adder datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one result bit per clock, LSB first, carry held in a flop.
// Handshake: start is taken only when ready (IDLE or DONE); busy is high while bits are
// being produced; done pulses for one cycle when sum/cout are updated.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum;
  logic             fa_cout;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            carry   <= cin;
            cnt     <= '0;
            busy    <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
          carry  <= fa_cout;
          cnt    <= cnt + 1'b1;
          // Last bit: publish the fully shifted sum in the same edge it is formed.
          if (cnt == LAST) begin
            sum     <= {fa_sum, sum_sr[WIDTH-1:1]};
            cout    <= fa_cout;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
